serializer_fsm: RTL and testbench

Parallel-to-serial converter for the FIR filter I/O path; the transmit-side counterpart of `deserializer_fsm`. It accepts a LENGTH-bit word over a valid/ready handshake and emits it LSB first, one bit per clock, as a contiguous valid-qualified burst. Its serial output is wired directly to the receive side of `deserializer_fsm` (`i_din`, `i_din_valid`, `o_ready`).

---
 rtl/fir_serdes_pkg.sv | 17 +
 rtl/serializer_fsm.sv | 117 +++++++++++
 tb/tb_serializer_fsm.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_serdes_pkg.sv
// Shared types and helpers for the FIR filter serial I/O path
// (serializer_fsm on the transmit side, deserializer_fsm on the receive side).
package fir_serdes_pkg;

  // Handshake/transfer phases shared by both ends of the serial link
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    SHIFT    = 2'd2
  } serdes_state_t;

  // Width of a bit counter that must be able to hold the value len
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/serializer_fsm.sv
// Parallel-to-serial converter for the FIR filter I/O path.
// Accepts a LENGTH-bit word over valid/ready and emits it LSB first as a
// contiguous valid-qualified burst, one bit per enabled clock.
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit
// after the data bits (frame becomes LENGTH+1 bits). Leave it undefined when
// the link feeds a plain deserializer_fsm.
module serializer_fsm
  import fir_serdes_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [LENGTH-1:0] iv_din,
  input  logic              i_din_valid,
  input  logic              i_ready,
  output logic              o_ready,
  output logic              o_dout,
  output logic              o_dout_valid
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FrameLen = LENGTH + 1;
`else
  localparam int FrameLen = LENGTH;
`endif

  localparam int CntW = cnt_width(LENGTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  serdes_state_t         state_q, state_d;
  logic [CntW-1:0]       bitCnt_q, bitCnt_d;
  logic [FrameLen-1:0]   shiftReg_q, shiftReg_d;
  logic                  ready_q, ready_d;
  logic                  dout_q, dout_d;
  logic                  doutValid_q, doutValid_d;

  // Next-state and registered-output logic; a low enable freezes everything
  // except the valid flag, which must drop for every disabled cycle
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shiftReg_d  = shiftReg_q;
    ready_d     = ready_q;
    dout_d      = dout_q;
    doutValid_d = 1'b0;

    if (i_en) begin
      unique case (state_q)
        IDLE: begin
          ready_d = 1'b1;
          if (i_din_valid && ready_q) begin
`ifdef SERIALIZER_PARITY_EN
            shiftReg_d = {^iv_din, iv_din};
`else
            shiftReg_d = iv_din;
`endif
            bitCnt_d = '0;
            ready_d  = 1'b0;
            state_d  = WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          ready_d = 1'b0;
          if (i_ready) begin
            state_d = SHIFT;
          end
        end

        SHIFT: begin
          ready_d     = 1'b0;
          dout_d      = shiftReg_q[0];
          doutValid_d = 1'b1;
          shiftReg_d  = {1'b0, shiftReg_q[FrameLen-1:1]};
          if (bitCnt_q == LastCnt) begin
            bitCnt_d = '0;
            state_d  = IDLE;
          end else begin
            bitCnt_d = bitCnt_q + CntOne;
          end
        end

        default: begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers; reset abandons any partial frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      ready_q     <= 1'b0;
      dout_q      <= 1'b0;
      doutValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shiftReg_q  <= shiftReg_d;
      ready_q     <= ready_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_dout       = dout_q;
  assign o_dout_valid = doutValid_q;

endmodule

// File: tb/tb_serializer_fsm.sv
// Self-checking bench for serializer_fsm (LENGTH = 32).
// A passive link model turns every accepted word into its expected bit stream
// and reassembles received frames; directed sequences check timing corners.
// Parity expectations follow SERIALIZER_PARITY_EN when it is defined.
module tb_serializer_fsm;

  localparam int Length = 32;
`ifdef SERIALIZER_PARITY_EN
  localparam int FrameLen = Length + 1;
`else
  localparam int FrameLen = Length;
`endif

  logic              i_clk;
  logic              i_rst;
  logic              i_en;
  logic [Length-1:0] iv_din;
  logic              i_din_valid;
  logic              i_ready;
  logic              o_ready;
  logic              o_dout;
  logic              o_dout_valid;

  int total = 0;
  int bad   = 0;

  // Link model state
  logic        expQ[$];
  int          acceptCyc[$];
  logic [63:0] rxWords[$];
  logic [63:0] rxAcc = '0;
  int          rxCount = 0;
  logic        lastDout = 1'b0;
  logic        enAtEdge = 1'b0;
  int          cyc = 0;

  typedef struct {
    logic [31:0] word;
    int          readyDelay;
    logic [31:0] expWord;
    int          expLatency;
    logic        expParity;
  } vec_t;

  vec_t vecs[6];

  serializer_fsm #(.LENGTH(Length)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .iv_din       (iv_din),
    .i_din_valid  (i_din_valid),
    .i_ready      (i_ready),
    .o_ready      (o_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid)
  );

  // Free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Edge counter and enable seen at each edge
  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
      enAtEdge = i_en;
    end
  end

  // Link model: expected stream per accepted word, frame reassembly
  initial begin
    logic expBit;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        expQ.delete();
        rxCount  = 0;
        rxAcc    = '0;
        lastDout = 1'b0;
      end else begin
        if (o_ready) checkOutput("readyOnlyWhenIdle", 64'(expQ.size()), 0);
        if (o_dout_valid) begin
          checkOutput("validNeedsEnable", 64'(enAtEdge), 1);
          checkOutput("bitHasFrame", 64'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            expBit = expQ.pop_front();
            checkOutput("serialBit", 64'(o_dout), 64'(expBit));
          end
          rxAcc[rxCount] = o_dout;
          rxCount++;
          if (rxCount == FrameLen) begin
            rxWords.push_back(rxAcc);
            rxAcc   = '0;
            rxCount = 0;
          end
        end else begin
          checkOutput("doutHold", 64'(o_dout), 64'(lastDout));
        end
        lastDout = o_dout;
        if (i_en && i_din_valid && o_ready) begin
          for (int i = 0; i < Length; i++) expQ.push_back(iv_din[i]);
`ifdef SERIALIZER_PARITY_EN
          expQ.push_back(^iv_din);
`endif
          acceptCyc.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic waitReady(input string name);
    int guard;
    guard = 0;
    while (!o_ready && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput(name, 64'(o_ready), 1);
  endtask

  // Send one word, hold i_ready low for readyDelay cycles, collect the frame
  task automatic applyStimulus(input logic [31:0] word, input int readyDelay,
                               output logic [63:0] recovered, output int latency, output int gaps);
    int guard;
    waitReady("readyBeforeAccept");
    iv_din      = word;
    i_din_valid = 1'b1;
    i_ready     = 1'b0;
    tick();
    i_din_valid = 1'b0;
    iv_din      = $urandom();
    for (int d = 0; d < readyDelay; d++) begin
      tick();
      checkOutput("waitValidLow", 64'(o_dout_valid), 0);
      checkOutput("waitReadyLow", 64'(o_ready), 0);
    end
    i_ready = 1'b1;
    latency = 0;
    while (!o_dout_valid && latency < 50) begin
      tick();
      latency++;
    end
    i_ready   = 1'b0;
    recovered = '0;
    gaps      = 0;
    for (int n = 0; n < FrameLen; n++) begin
      guard = 0;
      while (!o_dout_valid && guard < 10) begin
        tick();
        gaps++;
        guard++;
      end
      recovered[n] = o_dout;
      tick();
    end
    checkOutput("validFallsAfterFrame", 64'(o_dout_valid), 0);
    checkOutput("readyRisesAfterFrame", 64'(o_ready), 1);
  endtask

  // Directed sequences, table vectors, then randomized traffic
  initial begin
    logic [63:0] rec;
    int          lat;
    int          gaps;
    int          n;
    int          guard;

    vecs[0] = '{32'h00FF00FF, 0,  32'h00FF00FF, 2, 1'b0};
    vecs[1] = '{32'h12345678, 3,  32'h12345678, 2, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 1,  32'hFFFFFFFF, 2, 1'b0};
    vecs[3] = '{32'h00000001, 20, 32'h00000001, 2, 1'b1};
    vecs[4] = '{32'h80000000, 0,  32'h80000000, 2, 1'b1};
    vecs[5] = '{32'h00000007, 0,  32'h00000007, 2, 1'b1};

    i_rst       = 1'b1;
    i_en        = 1'b1;
    i_din_valid = 1'b0;
    i_ready     = 1'b0;
    iv_din      = '0;

    // Reset values and first enabled edge after release
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("resetReady", 64'(o_ready), 0);
    checkOutput("resetDout", 64'(o_dout), 0);
    checkOutput("resetValid", 64'(o_dout_valid), 0);
    i_rst = 1'b0;
    #1;
    checkOutput("readyBeforeFirstEdge", 64'(o_ready), 0);
    tick();
    checkOutput("readyAfterFirstEdge", 64'(o_ready), 1);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].word, vecs[v].readyDelay, rec, lat, gaps);
      checkOutput($sformatf("vecWord%0d", v), 64'(rec[31:0]), 64'(vecs[v].expWord));
      checkOutput($sformatf("vecLatency%0d", v), 64'(lat), 64'(vecs[v].expLatency));
      checkOutput($sformatf("vecGaps%0d", v), 64'(gaps), 0);
`ifdef SERIALIZER_PARITY_EN
      checkOutput($sformatf("vecParity%0d", v), 64'(rec[32]), 64'(vecs[v].expParity));
`endif
    end

    // Back-to-back words with valid held high
    waitReady("b2bReady");
    acceptCyc.delete();
    rxWords.delete();
    i_ready     = 1'b1;
    iv_din      = 32'hFF00FF00;
    i_din_valid = 1'b1;
    tick();
    iv_din = 32'hAF5EB900;
    guard  = 0;
    while (acceptCyc.size() < 2 && guard < 100) begin
      tick();
      guard++;
    end
    i_din_valid = 1'b0;
    guard = 0;
    while (rxWords.size() < 2 && guard < 200) begin
      tick();
      guard++;
    end
    i_ready = 1'b0;
    checkOutput("b2bAccepts", 64'(acceptCyc.size()), 2);
    checkOutput("b2bFrames", 64'(rxWords.size()), 2);
    if (acceptCyc.size() >= 2) checkOutput("b2bPeriod", 64'(acceptCyc[1] - acceptCyc[0]), FrameLen + 3);
    if (rxWords.size() >= 2) begin
      checkOutput("b2bWord0", 64'(rxWords[0][31:0]), 64'h00000000FF00FF00);
      checkOutput("b2bWord1", 64'(rxWords[1][31:0]), 64'h00000000AF5EB900);
    end

    // Enable dropped for 3 cycles after bit 10
    waitReady("pauseReady");
    iv_din      = 32'hA5A5A5A5;
    i_din_valid = 1'b1;
    i_ready     = 1'b1;
    tick();
    i_din_valid = 1'b0;
    n = 0; gaps = 0; guard = 0; rec = '0;
    while (n < FrameLen && guard < 200) begin
      tick();
      guard++;
      if (o_dout_valid) begin
        rec[n] = o_dout;
        n++;
        if (n == 11) begin
          i_en = 1'b0;
          repeat (3) begin
            tick();
            checkOutput("pauseValidLow", 64'(o_dout_valid), 0);
          end
          i_en = 1'b1;
        end
      end else if (n > 0) begin
        gaps++;
      end
    end
    i_ready = 1'b0;
    tick();
    checkOutput("pauseBits", 64'(n), FrameLen);
    checkOutput("pauseWord", 64'(rec[31:0]), 64'h00000000A5A5A5A5);
    checkOutput("pauseGaps", 64'(gaps), 0);
    checkOutput("pauseEndValid", 64'(o_dout_valid), 0);

    // Reset after bit 5, then a clean frame
    waitReady("rstReady");
    iv_din      = 32'h3C3CF0F0;
    i_din_valid = 1'b1;
    i_ready     = 1'b1;
    tick();
    i_din_valid = 1'b0;
    n = 0; guard = 0;
    while (n < 6 && guard < 100) begin
      tick();
      guard++;
      if (o_dout_valid) n++;
    end
    checkOutput("rstBitsSeen", 64'(n), 6);
    i_rst = 1'b1;
    #1;
    checkOutput("rstMidReady", 64'(o_ready), 0);
    checkOutput("rstMidDout", 64'(o_dout), 0);
    checkOutput("rstMidValid", 64'(o_dout_valid), 0);
    tick();
    i_rst   = 1'b0;
    i_ready = 1'b0;
    tick();
    checkOutput("rstReleaseReady", 64'(o_ready), 1);
    applyStimulus(32'h12345678, 0, rec, lat, gaps);
    checkOutput("postRstWord", 64'(rec[31:0]), 64'h0000000012345678);
    checkOutput("postRstLatency", 64'(lat), 2);
`ifdef SERIALIZER_PARITY_EN
    checkOutput("postRstParity", 64'(rec[32]), 1);
`endif

    // Randomized traffic checked by the link model
    rxWords.delete();
    for (int c = 0; c < 2000; c++) begin
      i_en        = ($urandom_range(0, 9) != 0);
      i_ready     = 1'($urandom_range(0, 1));
      i_din_valid = 1'($urandom_range(0, 1));
      iv_din      = $urandom();
      tick();
    end
    i_en        = 1'b1;
    i_ready     = 1'b1;
    i_din_valid = 1'b0;
    guard = 0;
    while ((expQ.size() != 0 || !o_ready) && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("drainEmpty", 64'(expQ.size()), 0);
    checkOutput("drainReady", 64'(o_ready), 1);
    checkOutput("randomActivity", 64'(rxWords.size() > 10), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
